// File: rtl/sweep_player.sv
// -----------------------------------------------------------------------------
// sweep_player -- multi-mode pitch-sweep tone generator for the piezo driver.
//
// Produces a piezo Counter Limit (50 MHz / (2*Freq)) plus a play enable.
// The pitch advances on "step events", one every TICK_DIV pulses of the
// 1 ms i_tick strobe. There are four sweep shapes, and an optional repeat
// count ends the run with a one-cycle o_done pulse.
//
// Ports:
//   clk        in   system clock (50 MHz)
//   rst        in   synchronous, active-low reset
//   i_tick     in   1 ms single-cycle strobe
//   i_enable   in   run request (level)
//   i_mode     in   0 triangle, 1 saw up-freq, 2 saw down-freq, 3 two-tone
//   i_cycles   in   sweep periods to play, 0 = endless
//   o_play_en  out  piezo on
//   o_pitch    out  piezo Counter Limit, always within [HIGH_LIMIT, LOW_LIMIT]
//   o_busy     out  high while running
//   o_done     out  one-cycle pulse after i_cycles periods
//
// Optional build macro: SWEEP_EXP_STEP_EN. When defined, modes 0-2 use an
// exponential step of max(1, pitch >> EXP_SHIFT). When undefined, the step
// is the constant STEP.
// -----------------------------------------------------------------------------
module sweep_player #(
    parameter int unsigned PITCH_W    = 32,
    parameter int unsigned LOW_LIMIT  = 62500,
    parameter int unsigned HIGH_LIMIT = 25000,
    parameter int unsigned STEP       = 25,
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned DWELL      = 250,
    parameter int unsigned EXP_SHIFT  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tick,
    input  logic               i_enable,
    input  logic [1:0]         i_mode,
    input  logic [7:0]         i_cycles,
    output logic               o_play_en,
    output logic [PITCH_W-1:0] o_pitch,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [PITCH_W-1:0] LOW_P    = PITCH_W'(LOW_LIMIT);
    localparam logic [PITCH_W-1:0] HIGH_P   = PITCH_W'(HIGH_LIMIT);
    localparam logic [PITCH_W-1:0] STEP_P   = PITCH_W'(STEP);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DW_W-1:0]    DW_LAST  = DW_W'(DWELL - 1);

    // Elaboration-time sanity check of the parameter set.
    if (HIGH_LIMIT >= LOW_LIMIT || TICK_DIV < 1 || DWELL < 1 || EXP_SHIFT >= PITCH_W) begin : g_bad_cfg
        $error("sweep_player: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [7:0]         cycles_q;
    logic [7:0]         period_q;
    logic [PRE_W-1:0]   pre_q;
    logic [DW_W-1:0]    dwell_q;
    logic               up_q;       // triangle direction: 1 = heading back to LOW_LIMIT
    logic [PITCH_W-1:0] pitch_q;
    logic               play_q;
    logic               busy_q;
    logic               done_q;

    logic               step_ev;
    logic [PITCH_W-1:0] step_w;
    logic [PITCH_W-1:0] room_dn;
    logic [PITCH_W-1:0] room_up;
    logic [PITCH_W-1:0] pitch_d;
    logic               up_d;
    logic [DW_W-1:0]    dwell_d;
    logic [7:0]         period_d;
    logic               period_end;

    // Next pitch if the current tick turns out to be a step event.
    always_comb begin
        step_ev = i_tick && (pre_q == PRE_LAST);
`ifdef SWEEP_EXP_STEP_EN
        step_w = pitch_q >> EXP_SHIFT;
        if (step_w == '0) begin
            step_w = PITCH_W'(1);
        end
`else
        step_w = STEP_P;
`endif
        // The pitch stays in range, so these differences cannot underflow.
        // Comparing them with the step avoids wrap-around in the add/subtract.
        room_dn    = pitch_q - HIGH_P;
        room_up    = LOW_P - pitch_q;
        pitch_d    = pitch_q;
        up_d       = up_q;
        dwell_d    = dwell_q;
        period_end = 1'b0;
        period_d   = period_q + 8'd1;
        case (mode_q)
            2'd0: begin
                if (!up_q) begin
                    if (room_dn <= step_w) begin
                        pitch_d = HIGH_P;
                        up_d    = 1'b1;
                    end else begin
                        pitch_d = pitch_q - step_w;
                    end
                end else begin
                    if (room_up <= step_w) begin
                        pitch_d    = LOW_P;
                        up_d       = 1'b0;
                        period_end = 1'b1;
                    end else begin
                        pitch_d = pitch_q + step_w;
                    end
                end
            end
            2'd1: begin
                if (pitch_q == HIGH_P) begin
                    pitch_d    = LOW_P;
                    period_end = 1'b1;
                end else if (room_dn <= step_w) begin
                    pitch_d = HIGH_P;
                end else begin
                    pitch_d = pitch_q - step_w;
                end
            end
            2'd2: begin
                if (pitch_q == LOW_P) begin
                    pitch_d    = HIGH_P;
                    period_end = 1'b1;
                end else if (room_up <= step_w) begin
                    pitch_d = LOW_P;
                end else begin
                    pitch_d = pitch_q + step_w;
                end
            end
            default: begin
                if (dwell_q == DW_LAST) begin
                    dwell_d = '0;
                    if (pitch_q == LOW_P) begin
                        pitch_d = HIGH_P;
                    end else begin
                        pitch_d    = LOW_P;
                        period_end = 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'd0;
            cycles_q <= 8'd0;
            period_q <= 8'd0;
            pre_q    <= '0;
            dwell_q  <= '0;
            up_q     <= 1'b0;
            pitch_q  <= LOW_P;
            play_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pitch_q <= LOW_P;
                    if (i_enable) begin
                        state_q  <= S_RUN;
                        mode_q   <= i_mode;
                        cycles_q <= i_cycles;
                        period_q <= 8'd0;
                        pre_q    <= '0;
                        dwell_q  <= '0;
                        up_q     <= 1'b0;
                        play_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        pitch_q  <= (i_mode == 2'd2) ? HIGH_P : LOW_P;
                    end
                end
                S_RUN: begin
                    if (!i_enable) begin
                        // Abort: silent, no completion pulse.
                        state_q  <= S_IDLE;
                        play_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        pitch_q  <= LOW_P;
                        period_q <= 8'd0;
                        pre_q    <= '0;
                        dwell_q  <= '0;
                        up_q     <= 1'b0;
                    end else if (i_tick) begin
                        if (step_ev) begin
                            pre_q   <= '0;
                            pitch_q <= pitch_d;
                            up_q    <= up_d;
                            dwell_q <= dwell_d;
                            if (period_end) begin
                                period_q <= period_d;
                                if (cycles_q != 8'd0 && period_d == cycles_q) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                    play_q  <= 1'b0;
                                    busy_q  <= 1'b0;
                                    pitch_q <= LOW_P;
                                end
                            end
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Parked until enable drops, so a held enable never retriggers.
                    if (!i_enable) begin
                        state_q  <= S_IDLE;
                        period_q <= 8'd0;
                        pre_q    <= '0;
                        dwell_q  <= '0;
                        up_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    play_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    pitch_q <= LOW_P;
                end
            endcase
        end
    end

    assign o_play_en = play_q;
    assign o_pitch   = pitch_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_sweep_player.sv
// -----------------------------------------------------------------------------
// tb_sweep_player -- drives two sweep_player instances with identical inputs.
// u0 uses the default parameters. u1 uses small limits (100/40, step 25,
// TICK_DIV 3, DWELL 2). Expected outputs come from a per-instance model that
// computes the pitch directly from the step-event count with closed-form
// arithmetic.
// -----------------------------------------------------------------------------
module tb_sweep_player;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        tick;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  cyc;

    logic        play_o  [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic [31:0] pitch_o [2];

    sweep_player u0 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_enable(en), .i_mode(mode),
        .i_cycles(cyc), .o_play_en(play_o[0]), .o_pitch(pitch_o[0]),
        .o_busy(busy_o[0]), .o_done(done_o[0])
    );

    sweep_player #(
        .LOW_LIMIT(100), .HIGH_LIMIT(40), .STEP(25), .TICK_DIV(3), .DWELL(2)
    ) u1 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_enable(en), .i_mode(mode),
        .i_cycles(cyc), .o_play_en(play_o[1]), .o_pitch(pitch_o[1]),
        .o_busy(busy_o[1]), .o_done(done_o[1])
    );

    int n_cmp = 0;
    int n_mis = 0;

    typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
    mst_t st    [2];
    int   mmode [2];
    int   mcyc  [2];
    int   ticks [2];
    bit   mdone [2];

    function automatic int p_lo (input int d); return (d == 0) ? 62500 : 100; endfunction
    function automatic int p_hi (input int d); return (d == 0) ? 25000 : 40;  endfunction
    function automatic int p_stp(input int d); return 25; endfunction
    function automatic int p_td (input int d); return (d == 0) ? 1 : 3; endfunction
    function automatic int p_dw (input int d); return (d == 0) ? 250 : 2; endfunction

    // Number of step events needed to travel between the limits (last one clamped).
    function automatic int nsteps(input int d);
        return (p_lo(d) - p_hi(d) + p_stp(d) - 1) / p_stp(d);
    endfunction

    function automatic int period(input int d, input int m);
        case (m)
            0:       return 2 * nsteps(d);
            1, 2:    return nsteps(d) + 1;
            default: return 2 * p_dw(d);
        endcase
    endfunction

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    // Pitch after p step events into a period.
    function automatic int pitch_at(input int d, input int m, input int p);
        int n;
        n = nsteps(d);
        case (m)
            0:       return (p <= n) ? imax(p_hi(d), p_lo(d) - p_stp(d) * p)
                                     : imin(p_lo(d), p_hi(d) + p_stp(d) * (p - n));
            1:       return imax(p_hi(d), p_lo(d) - p_stp(d) * p);
            2:       return imin(p_lo(d), p_hi(d) + p_stp(d) * p);
            default: return (p < p_dw(d)) ? p_lo(d) : p_hi(d);
        endcase
    endfunction

    task automatic model_update(input int d);
        int ev;
        mdone[d] = 1'b0;
        if (!rst) begin
            st[d] = M_IDLE;
        end else begin
            case (st[d])
                M_IDLE: if (en) begin
                    st[d]    = M_RUN;
                    mmode[d] = int'(mode);
                    mcyc[d]  = int'(cyc);
                    ticks[d] = 0;
                end
                M_RUN: begin
                    if (!en) begin
                        st[d] = M_IDLE;
                    end else if (tick) begin
                        ticks[d]++;
                        ev = ticks[d] / p_td(d);
                        if ((ticks[d] % p_td(d)) == 0 && mcyc[d] != 0 &&
                            ev == mcyc[d] * period(d, mmode[d])) begin
                            st[d]    = M_DONE;
                            mdone[d] = 1'b1;
                        end
                    end
                end
                default: if (!en) st[d] = M_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input int d);
        int ep;
        bit run;
        run = (st[d] == M_RUN);
        ep  = run ? pitch_at(d, mmode[d], (ticks[d] / p_td(d)) % period(d, mmode[d])) : p_lo(d);
        chk($sformatf("u%0d.play_en", d), 32'(play_o[d]), 32'(run));
        chk($sformatf("u%0d.busy", d),    32'(busy_o[d]), 32'(run));
        chk($sformatf("u%0d.done", d),    32'(done_o[d]), 32'(mdone[d]));
        chk($sformatf("u%0d.pitch", d),   pitch_o[d],     32'(ep));
    endtask

    // One clock: the inputs already set are sampled, then the model advances and outputs are checked.
    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    int done_seen;

    initial begin
        rst = 1'b0; en = 1'b1; tick = 1'b0; mode = 2'd0; cyc = 8'd1;
        for (int d = 0; d < 2; d++) begin
            st[d] = M_IDLE; mmode[d] = 0; mcyc[d] = 0; ticks[d] = 0; mdone[d] = 1'b0;
        end

        // Reset held with enable high.
        repeat (3) step(1'($urandom_range(0, 1)));

        // Triangle, one period, then enable held in DONE for well over 100 ticks.
        rst = 1'b1;
        repeat (3700) step(1'($urandom_range(0, 7) != 0));
        repeat (150) step(1'b1);
        chk("u0.silent_after_done", 32'(play_o[0]), 32'd0);

        // Drop for one cycle, then saw up-freq x2 while i_mode is scrambled mid-run.
        en = 1'b0; step(1'b1);
        en = 1'b1; mode = 2'd1; cyc = 8'd2;
        step(1'b1);
        done_seen = 0;
        for (int i = 0; i < 200; i++) begin
            mode = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 3) != 0));
            if (done_o[1]) done_seen++;
        end
        chk("u1.done_pulses", 32'(done_seen), 32'd1);

        // Two-tone, endless.
        en = 1'b0; step(1'b0);
        en = 1'b1; mode = 2'd3; cyc = 8'd0;
        repeat (800) step(1'($urandom_range(0, 2) != 0));

        // Saw down-freq, three periods.
        en = 1'b0; step(1'b0);
        en = 1'b1; mode = 2'd2; cyc = 8'd3;
        repeat (300) step(1'($urandom_range(0, 1)));

        // Random modes and counts.
        for (int r = 0; r < 3; r++) begin
            en = 1'b0; step(1'b0);
            en = 1'b1; mode = 2'($urandom_range(0, 3)); cyc = 8'($urandom_range(1, 3));
            repeat (1200) step(1'($urandom_range(0, 3) != 0));
        end

        // Drop enable mid-sweep at pitch 50000.
        en = 1'b0; step(1'b0);
        en = 1'b1; mode = 2'd0; cyc = 8'd0;
        step(1'b1);
        repeat (500) step(1'b1);
        chk("u0.mid_pitch", pitch_o[0], 32'd50000);
        en = 1'b0; step(1'b1);
        chk("u0.abort_pitch", pitch_o[0], 32'd62500);

        // Reset mid-run.
        en = 1'b1; mode = 2'd1; cyc = 8'd5;
        repeat (60) step(1'b1);
        rst = 1'b0; step(1'b1);
        rst = 1'b1;
        repeat (60) step(1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
